// File: rtl/msgdma_desc_scheduler.sv
// Two-requester round-robin front end for an mSGDMA dispatcher: writes one
// four-word descriptor per accepted request, then waits for completion or a watchdog expiry.
module msgdma_desc_scheduler #(
    parameter int          LEN_W     = 32,
    parameter int          TIMEOUT   = 1000000,
    parameter logic [31:0] CTRL_WORD = 32'h8000_4000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [63:0]        req_addr,
    input  logic [2*LEN_W-1:0] req_len,
    output logic [1:0]         desc_address,
    output logic               desc_write,
    output logic [31:0]        desc_writedata,
    input  logic               desc_waitrequest,
    input  logic               dma_done,
    output logic [1:0]         done,
    output logic               timeout,
    output logic               busy,
    output logic               grant_id
);

    localparam int              WD_W     = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_COMPLETE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_word_cnt;
    logic [WD_W-1:0]  r_wd_cnt;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_len;
    logic             r_grant;
    logic             r_last_grant;
    logic [1:0]       r_done;
    logic             r_timeout;
    logic             r_busy;

    logic             w_winner;
    logic [1:0]       w_ready;
    logic             w_accept;
    logic [31:0]      w_sel_addr;
    logic [LEN_W-1:0] w_sel_len;
    logic             w_word_ack;
    logic             w_expire;
    logic             w_finish;
    logic [1:0]       w_next_state;
    logic [31:0]      w_len32;

    generate
        if (LEN_W >= 32) begin : g_len_trunc
            assign w_len32 = r_len[31:0];
        end else begin : g_len_ext
            assign w_len32 = {{(32-LEN_W){1'b0}}, r_len};
        end
    endgenerate

    // On contention the requester that did not win last time takes the grant.
    assign w_winner   = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_sel_addr = w_winner ? req_addr[63:32] : req_addr[31:0];
    assign w_sel_len  = w_winner ? req_len[LEN_W +: LEN_W] : req_len[LEN_W-1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_ready = 2'b00;
        // NOTE: reset_n gates the combinational ready so nothing is offered while the block is held in reset.
        if (reset_n && (r_state == S_IDLE) && (|req_valid))
            w_ready = w_winner ? 2'b10 : 2'b01;
    end

    assign w_accept   = |w_ready;
    assign w_word_ack = (r_state == S_WRITE) && !desc_waitrequest;
    assign w_expire   = (r_state == S_WAIT_DONE) && !dma_done && (r_wd_cnt == WD_LIMIT);
    assign w_finish   = (r_state == S_COMPLETE) || w_expire;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_accept)
                             w_next_state = (w_sel_len == '0) ? S_COMPLETE : S_WRITE;
            S_WRITE:     if (w_word_ack && (r_word_cnt == 2'd3))
                             w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (dma_done)
                             w_next_state = S_COMPLETE;
                         else if (r_wd_cnt == WD_LIMIT)
                             w_next_state = S_IDLE;
            S_COMPLETE:  w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_word_cnt   <= 2'd0;
            r_wd_cnt     <= '0;
            r_addr       <= 32'h0;
            r_len        <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_done       <= 2'b00;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_addr       <= w_sel_addr;
                r_len        <= w_sel_len;
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_word_cnt   <= 2'd0;
            end else if (w_word_ack) begin
                r_word_cnt <= r_word_cnt + 2'd1;
            end

            // Watchdog restarts on WAIT_DONE entry and saturates at the limit.
            if ((r_state == S_WRITE) && (w_next_state == S_WAIT_DONE))
                r_wd_cnt <= '0;
            else if ((r_state == S_WAIT_DONE) && (r_wd_cnt != WD_LIMIT))
                r_wd_cnt <= r_wd_cnt + WD_W'(1);

            r_done    <= (r_state == S_COMPLETE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
            r_timeout <= w_expire;
            // Busy covers the cycle carrying the done/timeout pulse, then drops.
            r_busy    <= (w_next_state != S_IDLE) || w_finish;
        end
    end

    always_comb begin
        desc_writedata = 32'h0;
        if (r_state == S_WRITE) begin
            case (r_word_cnt)
                2'd0:    desc_writedata = r_addr;
                2'd1:    desc_writedata = 32'h0;
                2'd2:    desc_writedata = w_len32;
                default: desc_writedata = CTRL_WORD;
            endcase
        end
    end

    assign desc_write   = (r_state == S_WRITE);
    assign desc_address = (r_state == S_WRITE) ? r_word_cnt : 2'd0;
    assign req_ready    = w_ready;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign busy         = r_busy;
    assign grant_id     = r_grant;

endmodule
